// File: rtl/cpu_sequencer.sv
// Fetch/execute control FSM for the 4-bit simple CPU.
// Steps the PC through program ROM, decodes each 8-bit instruction and raises one
// datapath strobe per EXEC cycle. A run stops on HLT or when the watchdog expires.
// Optional feature macro: SINGLE_STEP_EN adds a step input and a PAUSE state after
// every non-HLT EXEC.
module cpu_sequencer #(
  parameter int unsigned PC_W    = 4,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned WDT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rom_data,
  input  logic              alu_zero,
  output logic [PC_W-1:0]   rom_addr,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        alu_op,
  output logic              reg_a_we,
  output logic              reg_b_we,
  output logic              out_we,
  output logic              running,
  output logic              halted,
  output logic              wdt_fault
`ifdef SINGLE_STEP_EN
  ,
  input  logic              step
`endif
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StHalt, StPause} state_e;

  localparam logic [7:0] WdtMax = 8'(WDT_MAX);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      wdt_q, wdt_d;
  logic            fault_q, fault_d;
  logic            start_q;
  logic            start_rise;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_imm;
  logic [7:0]      wdt_inc;
  logic [3:0]      opcode;

  assign start_rise = start & ~start_q;
  assign pc_inc     = pc_q + 1'b1;
  assign pc_imm     = PC_W'(ir_q[3:0]);
  assign wdt_inc    = wdt_q + 8'd1;
  assign opcode     = ir_q[7:4];

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_rise;
  assign step_rise = step & ~step_q;

  // Step button edge detector, same scheme as start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`endif

  // State, PC, IR, watchdog and fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      wdt_q   <= '0;
      fault_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wdt_q   <= wdt_d;
      fault_q <= fault_d;
      start_q <= start;
    end
  end

  // Next-state logic and EXEC-cycle decode of strobes and ALU select.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    wdt_d    = wdt_q;
    fault_d  = fault_q;
    alu_op   = 2'b00;
    reg_a_we = 1'b0;
    reg_b_we = 1'b0;
    out_we   = 1'b0;
    case (state_q)
      StIdle, StHalt: begin
        if (start_rise) begin
          state_d = StFetch;
          pc_d    = '0;
          wdt_d   = '0;
          fault_d = 1'b0;
        end
      end
      StFetch: begin
        ir_d    = rom_data;
        state_d = StExec;
      end
      StExec: begin
        wdt_d = wdt_inc;
        pc_d  = pc_inc;
`ifdef SINGLE_STEP_EN
        state_d = StPause;
`else
        state_d = StFetch;
`endif
        case (opcode)
          4'h1: reg_a_we = 1'b1;
          4'h2: reg_b_we = 1'b1;
          4'h3: begin
            alu_op   = 2'b01;
            reg_a_we = 1'b1;
          end
          4'h4: begin
            alu_op   = 2'b10;
            reg_a_we = 1'b1;
          end
          4'h5: begin
            alu_op = 2'b11;
            out_we = 1'b1;
          end
          4'h6: pc_d = pc_imm;
          4'h7: begin
            alu_op = 2'b11;
            pc_d   = alu_zero ? pc_imm : pc_inc;
          end
          4'hF: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ;
        endcase
        // Watchdog expiry halts after this instruction; a real HLT takes precedence.
        if (opcode != 4'hF && wdt_inc == WdtMax) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end
      end
`ifdef SINGLE_STEP_EN
      StPause: begin
        if (step_rise) state_d = StFetch;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign rom_addr  = pc_q;
  assign pc        = pc_q;
  assign imm       = DATA_W'(ir_q[3:0]);
  assign running   = (state_q == StFetch) || (state_q == StExec) || (state_q == StPause);
  assign halted    = (state_q == StHalt);
  assign wdt_fault = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small ROM and register A/B/LED model.
// Single-step scenario is included only when SINGLE_STEP_EN is defined.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rom_data;
  logic       alu_zero;
  logic [3:0] rom_addr, pc, imm;
  logic [1:0] alu_op;
  logic       reg_a_we, reg_b_we, out_we, running, halted, wdt_fault;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  rom [16];
  logic [3:0]  a, b, led, alu_res;
  logic [15:0] a_mask, b_mask, o_mask, pc_mask;
  int          multi, starts;
  logic        run_prev = 1'b0;

  cpu_sequencer #(.PC_W(4), .DATA_W(4), .WDT_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_data(rom_data), .alu_zero(alu_zero),
    .rom_addr(rom_addr), .pc(pc), .imm(imm), .alu_op(alu_op), .reg_a_we(reg_a_we),
    .reg_b_we(reg_b_we), .out_we(out_we), .running(running), .halted(halted),
    .wdt_fault(wdt_fault)
`ifdef SINGLE_STEP_EN
    , .step(step)
`endif
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  // Datapath model: ALU result and A/B/LED registers.
  always_comb begin
    alu_res = imm;
    case (alu_op)
      2'b01:   alu_res = a + b;
      2'b10:   alu_res = a - b;
      2'b11:   alu_res = a;
      default: alu_res = imm;
    endcase
  end
  assign alu_zero = (alu_res == 4'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0; b <= '0; led <= '0;
    end else begin
      if (reg_a_we) a <= alu_res;
      if (reg_b_we) b <= alu_res;
      if (out_we)   led <= a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reg_a_we) a_mask[pc] = 1'b1;
      if (reg_b_we) b_mask[pc] = 1'b1;
      if (out_we)   o_mask[pc] = 1'b1;
      if (running)  pc_mask[pc] = 1'b1;
      if (32'(reg_a_we) + 32'(reg_b_we) + 32'(out_we) > 1) multi++;
      if (running && !run_prev) starts++;
      run_prev = running;
    end
  endtask

  task automatic clr();
    a_mask = '0; b_mask = '0; o_mask = '0; pc_mask = '0; multi = 0; starts = 0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
  endtask

  task automatic load_prog2();
    fill_halt();
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h30; rom[3] = 8'h22;
    rom[4] = 8'h40; rom[5] = 8'h50; rom[6] = 8'hF0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    load_prog2();
    clr();
    #23 rst_n = 1'b1;

    // Idle after reset with no start.
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle", {pc, running, halted, wdt_fault, reg_a_we, reg_b_we, out_we}, 0);
    end

    // Arithmetic program.
    clr();
    pulse_start();
    chk("p2_first_fetch", {running, pc}, {1'b1, 4'd0});
    cyc(13);
    chk("p2_exec_hlt", {halted, running, pc}, {1'b0, 1'b1, 4'd6});
    cyc(1);
    chk("p2_halted", {halted, running, wdt_fault, pc}, {1'b1, 1'b0, 1'b0, 4'd6});
    chk("p2_a_we", a_mask, 16'h0015);
    chk("p2_b_we", b_mask, 16'h000A);
    chk("p2_out_we", o_mask, 16'h0020);
    chk("p2_regs", {led, a, b}, {4'd6, 4'd6, 4'd2});
    cyc(5);
    chk("p2_pc_frozen", {halted, pc}, {1'b1, 4'd6});

    // Held start gives one run; a later rise reruns.
    clr();
    start = 1'b1;
    cyc(50);
    chk("held_one_run", starts, 1);
    chk("held_halted", {halted, pc}, {1'b1, 4'd6});
    start = 1'b0;
    cyc(2);
    clr();
    pulse_start();
    cyc(14);
    chk("rerun_runs", starts, 1);
    chk("rerun_halted", {halted, pc}, {1'b1, 4'd6});

    // Taken JZ.
    fill_halt();
    rom[0] = 8'h10; rom[1] = 8'h74; rom[2] = 8'h11; rom[4] = 8'h50;
    clr();
    pulse_start();
    cyc(8);
    chk("jz_halted", {halted, pc}, {1'b1, 4'd5});
    chk("jz_pc_seen", pc_mask, 16'h0033);
    chk("jz_out_we", o_mask, 16'h0010);
    chk("jz_led", led, 4'd0);

    // PC wrap 15->0, unknown opcode as NOP, JZ not taken.
    fill_halt();
    rom[0] = 8'h73; rom[3] = 8'h11; rom[4] = 8'h6F; rom[15] = 8'h80; rom[1] = 8'hF0;
    clr();
    pulse_start();
    cyc(12);
    chk("wrap_halted", {halted, pc}, {1'b1, 4'd1});
    chk("wrap_pc_seen", pc_mask, 16'h801B);
    chk("wrap_a_we", a_mask, 16'h0008);
    chk("wrap_a", a, 4'd1);

    // Watchdog on an endless JMP 0.
    fill_halt();
    rom[0] = 8'h60;
    clr();
    pulse_start();
    cyc(509);
    chk("wdt_before", {halted, running, wdt_fault}, {1'b0, 1'b1, 1'b0});
    cyc(1);
    chk("wdt_expired", {halted, running, wdt_fault, pc}, {1'b1, 1'b0, 1'b1, 4'd0});
    cyc(1);
    pulse_start();
    chk("wdt_restart_clears", {halted, running, wdt_fault}, {1'b0, 1'b1, 1'b0});
    cyc(101);
    chk("pre_reset_running", running, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {pc, running, halted, wdt_fault, reg_a_we, reg_b_we, out_we}, 0);
    cyc(3);
    chk("in_reset", {pc, running, halted, wdt_fault}, 0);
    rst_n = 1'b1;
    cyc(3);
    chk("after_reset_idle", {pc, running, halted}, 0);

`ifdef SINGLE_STEP_EN
    // One instruction per step edge.
    load_prog2();
    clr();
    pulse_start();
    cyc(3);
    chk("ss_paused", {running, halted, pc}, {1'b1, 1'b0, 4'd1});
    chk("ss_first_a_we", a_mask, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(3);
    end
    chk("ss_halted", {halted, running, pc}, {1'b1, 1'b0, 4'd6});
    chk("ss_a_we", a_mask, 16'h0015);
    chk("ss_out_we", o_mask, 16'h0020);
`endif

    chk("no_double_strobe", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
